// File: rtl/aes_enc_dec_display_if.sv
// Signal bundle for aes_enc_dec_display: run control and data in, results and seven-segment display out.
interface aes_enc_dec_display_if #(
   parameter int NR = 10
) ();
   logic                  start;
   logic [127:0]          message;
   logic [128*(NR+1)-1:0] key_schedule;
   logic [127:0]          out_reg;
   logic [127:0]          cipher_out;
   logic                  busy;
   logic                  done;
   logic [6:0]            HEX2;
   logic [6:0]            HEX1;
   logic [6:0]            HEX0;

   modport master (
      output start, message, key_schedule,
      input  out_reg, cipher_out, busy, done, HEX2, HEX1, HEX0
   );

   modport slave (
      input  start, message, key_schedule,
      output out_reg, cipher_out, busy, done, HEX2, HEX1, HEX0
   );
endinterface

// File: rtl/aes_enc_dec_display.sv
// Iterative AES: one round per clock, encrypts then decrypts the message in place,
// latching the ciphertext and showing the low byte of the working state in decimal.
module aes_enc_dec_display #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   aes_enc_dec_display_if.slave  bus
);
   localparam int CNT_W = $clog2(NR + 1);
   localparam int KS_W  = 128 * (NR + 1);

   if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_bad_cfg
      $error("aes_enc_dec_display: illegal NK/NR pair");
   end

   // Byte i of each table sits at [8*i +: 8]; ascending range keeps byte 0 leftmost.
   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [0:2047] invert_table(input logic [0:2047] fwd);
      logic [0:2047] inv;
      inv = '0;
      for (int i = 0; i < 256; i++) begin
         inv[8*int'(fwd[8*i +: 8]) +: 8] = 8'(i);
      end
      return inv;
   endfunction

   // Deriving the inverse table from the forward one guarantees the two always agree.
   localparam logic [0:2047] INV_SBOX_TBL = invert_table(SBOX_TBL);

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // GF(2^8) product with a 4-bit constant; covers the 9/11/13/14 inverse-mix factors.
   function automatic logic [7:0] gmul_c(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x2, x4, x8, r;
      x2 = xt(b);
      x4 = xt(x2);
      x8 = xt(x4);
      r  = 8'h00;
      if (c[0]) r = r ^ b;
      if (c[1]) r = r ^ x2;
      if (c[2]) r = r ^ x4;
      if (c[3]) r = r ^ x8;
      return r;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gmul_c(a0, 4'd14) ^ gmul_c(a1, 4'd11) ^ gmul_c(a2, 4'd13) ^ gmul_c(a3, 4'd9),
              gmul_c(a0, 4'd9)  ^ gmul_c(a1, 4'd14) ^ gmul_c(a2, 4'd11) ^ gmul_c(a3, 4'd13),
              gmul_c(a0, 4'd13) ^ gmul_c(a1, 4'd9)  ^ gmul_c(a2, 4'd14) ^ gmul_c(a3, 4'd11),
              gmul_c(a0, 4'd11) ^ gmul_c(a1, 4'd13) ^ gmul_c(a2, 4'd9)  ^ gmul_c(a3, 4'd14)};
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENC, S_DEC, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [127:0]       out_reg_q, out_reg_d;
   logic [127:0]       cipher_q, cipher_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [127:0]       rk_arr [NR+1];
   logic [CNT_W-1:0]   rk_idx_w;
   logic [127:0]       rk_w;
   logic [127:0]       sb_w, sr_w, mc_w, enc_w;
   logic [127:0]       isr_w, isb_w, dec_ark_w, imc_w, dec_w;
   logic               first_w, last_w;

   for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
      assign rk_arr[gi] = bus.key_schedule[KS_W-1-128*gi -: 128];
   end

   // Bytes are column-major: index = 4*column + row, byte 0 in the top bits.
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW     = gi % 4;
      localparam int COL     = gi / 4;
      localparam int SR_SRC  = 4*((COL + ROW) % 4) + ROW;
      localparam int ISR_SRC = 4*((COL + 4 - ROW) % 4) + ROW;
      assign sb_w[127-8*gi -: 8]  = SBOX_TBL[8*int'(out_reg_q[127-8*gi -: 8]) +: 8];
      assign sr_w[127-8*gi -: 8]  = sb_w[127-8*SR_SRC -: 8];
      assign isr_w[127-8*gi -: 8] = out_reg_q[127-8*ISR_SRC -: 8];
      assign isb_w[127-8*gi -: 8] = INV_SBOX_TBL[8*int'(isr_w[127-8*gi -: 8]) +: 8];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign mc_w[127-32*gi -: 32]  = mix_col(sr_w[127-32*gi -: 32]);
      assign imc_w[127-32*gi -: 32] = inv_mix_col(dec_ark_w[127-32*gi -: 32]);
   end

   assign first_w   = (cnt_q == '0);
   assign last_w    = (cnt_q == CNT_W'(NR));
   assign rk_idx_w  = (state_q == S_DEC) ? CNT_W'(NR) - cnt_q : cnt_q;
   assign rk_w      = rk_arr[rk_idx_w];
   assign enc_w     = first_w ? (out_reg_q ^ rk_w) : ((last_w ? sr_w : mc_w) ^ rk_w);
   assign dec_ark_w = isb_w ^ rk_w;
   assign dec_w     = first_w ? (out_reg_q ^ rk_w) : (last_w ? dec_ark_w : imc_w);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      out_reg_d = out_reg_q;
      cipher_d  = cipher_q;
      busy_d    = busy_q;
      done_d    = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               out_reg_d = bus.message;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               cnt_d     = '0;
               state_d   = S_ENC;
            end
         end
         S_ENC: begin
            out_reg_d = enc_w;
            if (last_w) begin
               cipher_d = enc_w;
               cnt_d    = '0;
               state_d  = S_DEC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DEC: begin
            out_reg_d = dec_w;
            if (last_w) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            // The message load happens on the start edge itself, so LOAD is never held.
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         out_reg_q <= '0;
         cipher_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         out_reg_q <= out_reg_d;
         cipher_q  <= cipher_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   logic [7:0] disp_b;
   logic [3:0] digit [3];
   logic [6:0] seg_w [3];

   assign disp_b   = out_reg_q[7:0];
   assign digit[2] = 4'(disp_b / 8'd100);
   assign digit[1] = 4'((disp_b / 8'd10) % 8'd10);
   assign digit[0] = 4'(disp_b % 8'd10);

   for (genvar gi = 0; gi < 3; gi++) begin : g_seg
      assign seg_w[gi] = seg7(digit[gi]);
   end

   assign bus.out_reg    = out_reg_q;
   assign bus.cipher_out = cipher_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.HEX2       = seg_w[2];
   assign bus.HEX1       = seg_w[1];
   assign bus.HEX0       = seg_w[0];
endmodule

// File: tb/tb_aes_enc_dec_display.sv
// Runs all three key sizes side by side against a byte-level AES model built from first principles.
`timescale 1ns/1ps
module tb_aes_enc_dec_display;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         start;
   logic [127:0] message;
   logic [127:0] rk_tbl [3][15];

   logic [2:0][127:0] out_a;
   logic [2:0][127:0] ciph_a;
   logic [2:0]        busy_a;
   logic [2:0]        done_a;
   logic [2:0][20:0]  hex_a;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] cipher_m [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int NK_G = 4 + 2*gi;
      localparam int NR_G = NK_G + 6;
      aes_enc_dec_display_if #(.NR(NR_G)) bus ();
      aes_enc_dec_display #(.NK(NK_G), .NR(NR_G)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus.slave)
      );
      assign bus.start   = start;
      assign bus.message = message;
      for (genvar gr = 0; gr <= NR_G; gr++) begin : g_rk
         assign bus.key_schedule[128*(NR_G-gr) +: 128] = rk_tbl[gi][gr];
      end
      assign out_a[gi]  = bus.out_reg;
      assign ciph_a[gi] = bus.cipher_out;
      assign busy_a[gi] = bus.busy;
      assign done_a[gi] = bus.done;
      assign hex_a[gi]  = {bus.HEX2, bus.HEX1, bus.HEX0};
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
   task automatic init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
   endfunction

   task automatic model_expand(input int d, input logic [255:0] key);
      int          nk, nr;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      nk   = 4 + 2*d;
      nr   = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk_tbl[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] model_encrypt(input int d, input logic [127:0] pt);
      int           nr;
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [127:0] s;
      nr = 10 + 2*d;
      s  = pt ^ rk_tbl[d][0];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               b[4*c+row] = sbox_m[a[4*((c+row)%4)+row]];
         if (r < nr) begin
            for (int c = 0; c < 4; c++)
               for (int row = 0; row < 4; row++)
                  a[4*c+row] = gmul(8'h02, b[4*c+row]) ^ gmul(8'h03, b[4*c+(row+1)%4])
                             ^ b[4*c+(row+2)%4] ^ b[4*c+(row+3)%4];
         end else begin
            a = b;
         end
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
         s = s ^ rk_tbl[d][r];
      end
      return s;
   endfunction

   function automatic logic [6:0] seg_m(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [20:0] hex_exp(input int v);
      return {seg_m(v / 100), seg_m((v / 10) % 10), seg_m(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("%s out_reg d%0d", tag, d), out_a[d], 128'h0);
         check_eq($sformatf("%s cipher_out d%0d", tag, d), ciph_a[d], 128'h0);
         check_eq($sformatf("%s busy d%0d", tag, d), 128'(busy_a[d]), 128'h0);
         check_eq($sformatf("%s done d%0d", tag, d), 128'(done_a[d]), 128'h0);
         check_eq($sformatf("%s hex d%0d", tag, d), 128'(hex_a[d]), 128'(hex_exp(0)));
      end
   endtask

   task automatic do_run(input string name, input logic [255:0] key, input logic [127:0] msg,
                         input bit kat, input bit hold);
      int nr;
      for (int d = 0; d < 3; d++) begin
         model_expand(d, key);
         cipher_m[d] = model_encrypt(d, msg);
      end
      if (kat) begin
         cipher_m[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
         cipher_m[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
         cipher_m[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
      end
      message = msg;
      start   = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("%s load d%0d", name, d), out_a[d], msg);
         check_eq($sformatf("%s busy_at_start d%0d", name, d), 128'(busy_a[d]), 128'h1);
         check_eq($sformatf("%s done_at_start d%0d", name, d), 128'(done_a[d]), 128'h0);
      end
      for (int k = 1; k <= 31; k++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            nr = 10 + 2*d;
            if (k == nr + 1) begin
               check_eq($sformatf("%s cipher out_reg d%0d", name, d), out_a[d], cipher_m[d]);
               check_eq($sformatf("%s cipher_out d%0d", name, d), ciph_a[d], cipher_m[d]);
               check_eq($sformatf("%s cipher hex d%0d", name, d), 128'(hex_a[d]),
                        128'(hex_exp(int'(cipher_m[d][7:0]))));
               check_eq($sformatf("%s busy_mid d%0d", name, d), 128'(busy_a[d]), 128'h1);
            end
            if (k == 2*nr + 2) begin
               check_eq($sformatf("%s plain out_reg d%0d", name, d), out_a[d], msg);
               check_eq($sformatf("%s done d%0d", name, d), 128'(done_a[d]), 128'h1);
               check_eq($sformatf("%s busy_end d%0d", name, d), 128'(busy_a[d]), 128'h0);
               check_eq($sformatf("%s plain hex d%0d", name, d), 128'(hex_a[d]),
                        128'(hex_exp(int'(msg[7:0]))));
            end
            if (hold && k == 2*nr + 3) begin
               check_eq($sformatf("%s restart out_reg d%0d", name, d), out_a[d], msg);
               check_eq($sformatf("%s restart busy d%0d", name, d), 128'(busy_a[d]), 128'h1);
               check_eq($sformatf("%s restart done d%0d", name, d), 128'(done_a[d]), 128'h0);
            end
         end
      end
      start = 1'b0;
      $display("run %s: msg=%h low=%0d cipher128=%h", name, msg, msg[7:0], cipher_m[0]);
   endtask

   task automatic reset_mid_run();
      message = {$urandom, $urandom, $urandom, $urandom};
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 reset = 1'b0;
      #1;
      check_reset_state("midrun_reset");
      tick();
      reset = 1'b1;
      repeat (5) tick();
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("no_autostart busy d%0d", d), 128'(busy_a[d]), 128'h0);
         check_eq($sformatf("no_autostart out_reg d%0d", d), out_a[d], 128'h0);
      end
      $display("run midrun_reset: reset applied 5 edges into run");
   endtask

   initial begin
      logic [255:0] kat_key;
      logic [255:0] key;
      logic [127:0] msg;
      reset   = 1'b0;
      start   = 1'b0;
      message = '0;
      for (int i = 0; i < 32; i++) kat_key[255-8*i -: 8] = 8'(i);
      init_sbox();
      #2;
      check_reset_state("reset");
      tick();
      tick();
      reset = 1'b1;
      tick();

      do_run("kat", kat_key, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0);
      reset_mid_run();
      do_run("kat_after_reset", kat_key, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0);

      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      msg = {$urandom, $urandom, $urandom, $urandom};
      do_run("hold_start", key, msg, 1'b0, 1'b1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 256; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         msg = {$urandom, $urandom, $urandom, $urandom};
         msg[7:0] = 8'(i);
         do_run($sformatf("rand%0d", i), key, msg, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/aes_enc_dec_display.md
AES_ENC_DEC_DISPLAY -- requirements
Module: aes_enc_dec_display

Interface
REQ-001 Parameter NK, default 4, key length in 32-bit words; legal pairs (NK,NR) SHALL be (4,10), (6,12), (8,14).
REQ-002 Parameter NR, default 10, number of AES rounds.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  sampled high in IDLE begins one encrypt-then-decrypt run.
REQ-006 message  input  128  plaintext; byte 0 at bits [127:120].
REQ-007 key_schedule  input  128*(NR+1)  expanded round keys per FIPS-197; round key 0 in the most-significant 128 bits.
REQ-008 out_reg  output  128  current state value being displayed.
REQ-009 cipher_out  output  128  ciphertext latched at end of encryption.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high once the run completes; held until next start or reset.
REQ-012 HEX2, HEX1, HEX0  output  7 each  seven-segment hundreds/tens/units of out_reg[7:0] in decimal.

Function
REQ-013 States SHALL be IDLE, LOAD, ENC, DEC, DONE; a round counter cnt (0..NR) SHALL sequence ENC and DEC.
REQ-014 IDLE or DONE with start=1 at an edge: out_reg<=message, busy<=1, done<=0, go to ENC with cnt=0.
REQ-015 ENC, one round per edge: cnt=0 AddRoundKey(rk0); cnt=1..NR-1 SubBytes, ShiftRows, MixColumns, AddRoundKey(rk cnt); cnt=NR the same without MixColumns.
REQ-016 On the ENC cnt=NR edge, cipher_out SHALL also load the ciphertext; go to DEC with cnt=0.
REQ-017 DEC, inverse cipher, one round per edge: cnt=0 AddRoundKey(rk NR); cnt=1..NR-1 InvShiftRows, InvSubBytes, AddRoundKey(rk NR-cnt), InvMixColumns; cnt=NR InvShiftRows, InvSubBytes, AddRoundKey(rk0).
REQ-018 After the DEC cnt=NR edge: busy<=0, done<=1, state DONE; out_reg SHALL hold the recovered plaintext.
REQ-019 Latency: ciphertext SHALL appear on out_reg NR+1 edges after the start edge, and plaintext 2*NR+2 edges after it.
REQ-020 start while busy SHALL be ignored; message and key_schedule SHALL be stable while busy.
REQ-021 S-box and inverse S-box SHALL match FIPS-197, and MixColumns SHALL use GF(2^8) with polynomial 0x11B.
REQ-022 HEX outputs SHALL be combinational from out_reg[7:0] (0..255) to three decimal digits.
REQ-023 Each HEX digit SHALL be active-low, with bit0=a through bit6=g: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 HEX2 SHALL show 0 (1000000) for values below 100; no leading-zero blanking.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, cnt=0, out_reg=0, cipher_out=0, busy=0, done=0, and HEX2/HEX1/HEX0 all showing 0.
REQ-026 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-027 After reset is released, the block SHALL require a new start.

Verification
REQ-028 NK=4/NR=10, key 000102..0f, message 00112233445566778899aabbccddeeff, start pulse -> after 11 edges out_reg=cipher_out=69c4e0d86a7b0430d8cdb78070b4c55a, HEX=0,9,0; after 22 edges out_reg=message, done=1, HEX=2,5,5.
REQ-029 NK=6/NR=12, key 000102..17, same message -> ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 after 13 edges (HEX=1,4,5); plaintext after 26 edges.
REQ-030 NK=8/NR=14, key 000102..1f, same message -> ciphertext 8ea2b7ca516745bfeafc49904b496089 after 15 edges (HEX=1,3,7); plaintext after 30 edges.
REQ-031 Reset pulsed at edge 5 of a run -> out_reg=0, busy=0, done=0 immediately; a new start then completes normally.
REQ-032 start held high throughout a run -> no restart while busy; a new run begins on the first edge in DONE.
REQ-033 Force out_reg[7:0] over 0..255 -> decoded HEX digits equal the decimal value for all 256 values.
